// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a show-ahead FIFO through its q/empty/rdreq port and presents the
// words as a valid/ready stream. It groups words into PKT_LEN-word packets and
// tags the final word of each packet with last_o. A 2-entry skid buffer keeps
// one word per cycle flowing while ready_i toggles. pkt_cnt_o counts the
// packets whose last word has completed a handshake.

module fifo_stream_reader #(
  parameter int DWIDTH  = 4,
  parameter int PKT_LEN = 4,
  parameter int PCNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              enable_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic [PCNT_W-1:0] pkt_cnt_o,
  output logic              busy_o
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [1:0]        occ_r;
  logic [DWIDTH-1:0] b0_data_r;
  logic [DWIDTH-1:0] b1_data_r;
  logic              b0_last_r;
  logic              b1_last_r;
  logic [PCNT_W-1:0] pkt_cnt_r;

  logic              window_s;
  logic              hs_s;
  logic              space_s;
  logic              pop_s;
  logic              tag_s;

  // Slot 0 is the head of the skid buffer; the stream is valid whenever it holds a word.
  assign valid_o   = (occ_r != 2'd0);
  assign hs_s      = valid_o & ready_i;
  assign window_s  = (state_r == ST_RUN) | (state_r == ST_DRAIN);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign space_s   = (occ_r < 2'd2) | ((occ_r == 2'd2) & hs_s);
  // Gating with srst_i keeps the FIFO untouched in the reset cycle.
  assign pop_s     = window_s & ~fifo_empty_i & space_s & ~srst_i;
  assign tag_s     = (idx_r == IDX_LAST);

  assign fifo_rdreq_o = pop_s;
  assign data_o       = valid_o ? b0_data_r : {DWIDTH{1'b0}};
  assign last_o       = valid_o & b0_last_r;
  assign pkt_cnt_o    = pkt_cnt_r;
  assign busy_o       = (state_r != ST_IDLE) | (occ_r != 2'd0);

  // Word index after this cycle's pop, wrapping at the packet boundary.
  always_comb begin
    idx_nxt_s = idx_r;
    if (pop_s) begin
      if (tag_s) begin
        idx_nxt_s = {IDX_W{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Next-state logic; RUN looks at the post-pop index so a word fetched while
  // enable_i falls is accounted to the right packet boundary.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enable_i) begin
          state_nxt_s = ST_RUN;
        end else if (idx_nxt_s == {IDX_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop_s & tag_s) begin
          if (enable_i) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and packet word index.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Skid buffer: pops append behind the current contents, handshakes shift the head out.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      occ_r     <= 2'd0;
      b0_data_r <= {DWIDTH{1'b0}};
      b1_data_r <= {DWIDTH{1'b0}};
      b0_last_r <= 1'b0;
      b1_last_r <= 1'b0;
    end else begin
      case ({pop_s, hs_s})
        2'b10: begin
          occ_r <= occ_r + 2'd1;
          if (occ_r == 2'd0) begin
            b0_data_r <= fifo_q_i;
            b0_last_r <= tag_s;
          end else begin
            b1_data_r <= fifo_q_i;
            b1_last_r <= tag_s;
          end
        end
        2'b01: begin
          occ_r     <= occ_r - 2'd1;
          b0_data_r <= b1_data_r;
          b0_last_r <= b1_last_r;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            b0_data_r <= fifo_q_i;
            b0_last_r <= tag_s;
          end else begin
            b0_data_r <= b1_data_r;
            b0_last_r <= b1_last_r;
            b1_data_r <= fifo_q_i;
            b1_last_r <= tag_s;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  // Count packets whose last word has been accepted by the consumer.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pkt_cnt_r <= {PCNT_W{1'b0}};
    end else if (hs_s & b0_last_r) begin
      pkt_cnt_r <= pkt_cnt_r + PCNT_W'(1);
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain-side companion to the team's show-ahead FIFO: pops words through the FIFO read port (q/empty/rdreq) and presents them as a valid/ready stream.
- Groups words into fixed-length packets and marks the final word of each packet with last_o.
- Holds up to 2 words in a skid buffer so full-rate flow survives ready_i deassertion.
- Sits between a FIFO instance and any stream consumer (serializer, packet sink).

Parameters:
DWIDTH, 4, data word width; must match the FIFO.
PKT_LEN, 4, words per packet, >= 1.
PCNT_W, 16, width of the sent-packet counter.

Ports:
clk_i  in  1  clock, all logic on rising edge
srst_i  in  1  synchronous reset, active-high
enable_i  in  1  request to stream; sampled each cycle
fifo_q_i  in  DWIDTH  FIFO head word (show-ahead: valid while fifo_empty_i=0)
fifo_empty_i  in  1  FIFO empty flag
fifo_rdreq_o  out  1  pop strobe to FIFO (combinational)
data_o  out  DWIDTH  stream data
valid_o  out  1  stream valid
last_o  out  1  final word of packet, qualified by valid_o
ready_i  in  1  consumer ready
pkt_cnt_o  out  PCNT_W  packets fully transferred (last-word handshakes)
busy_o  out  1  state != IDLE or buffer non-empty

Behaviour:
- Reset values: valid_o=0, last_o=0, data_o=0, pkt_cnt_o=0, busy_o=0, fifo_rdreq_o=0. State=IDLE, buffer occupancy=0, word index=0.
- Reset mid-packet discards buffered words and the partial index. No words are popped in the reset cycle.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable_i=1.
  - RUN -> IDLE when enable_i=0 and word index=0 (packet boundary).
  - RUN -> DRAIN when enable_i=0 and word index!=0.
  - DRAIN ignores enable_i until the fetch that completes the packet. At that edge it goes to RUN if enable_i=1, else IDLE.
- Fetch window is open in RUN and DRAIN only.
- fifo_rdreq_o = window_open & !fifo_empty_i & (occupancy<2 | (occupancy==2 & handshake this cycle)). Handshake = valid_o & ready_i.
- A pop writes fifo_q_i plus a last tag into the buffer at the same edge. Tag=1 when word index == PKT_LEN-1.
- Word index increments per pop and wraps PKT_LEN-1 -> 0. PKT_LEN=1: every word tagged last.
- Latency: word popped at edge N appears on data_o/valid_o in cycle N+1 (buffer empty case). Sustained 1 word/cycle with ready_i=1.
- Buffer is a 2-entry FIFO. Head drives data_o/last_o; valid_o = occupancy!=0.
- While valid_o=1 and ready_i=0, data_o/last_o are held stable. A word is never dropped or duplicated.
- Simultaneous pop and handshake: occupancy unchanged, order preserved.
- Output side drains the buffer in every state, including IDLE.
- pkt_cnt_o increments on a handshake with last_o=1 and wraps modulo 2^PCNT_W.
- data_o is 0 when valid_o=0.
- fifo_empty_i asserted: no pop. Pausing mid-packet on empty keeps the word index; the packet resumes when data arrives.

Test Plan:
- PKT_LEN=4. FIFO preloaded with 1..8, enable_i=1, ready_i=1 -> data_o 1..8 on consecutive cycles starting 1 cycle after the first pop. last_o on 4 and 8. pkt_cnt_o=2. fifo_rdreq_o high 8 cycles.
- Same preload, ready_i toggling 1,0,1,0 -> order 1..8 intact. data_o stable while ready_i=0. fifo_rdreq_o blocks once occupancy=2.
- enable_i dropped after 2 words popped -> DRAIN. Words 3,4 still popped, last_o on 4, FSM to IDLE. Word 5 stays in FIFO. busy_o falls after word 4 handshakes.
- FIFO holds 2 words, enable_i=1 -> words 1,2 sent, last_o=0, valid_o falls. Push 3,4 later -> 3,4 sent, last_o on 4, pkt_cnt_o=1.
- srst_i for 1 cycle with occupancy=2 mid-packet -> next cycle valid_o=0, pkt_cnt_o=0, fifo_rdreq_o=0. After re-enable, the next popped word is index 0 and last_o falls on the 4th word.
- PKT_LEN=1, PCNT_W=2, 5 words -> last_o on every word, pkt_cnt_o sequence 1,2,3,0,1.
